// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with extra-bit pointers.
// A pop on a full FIFO frees the slot for a push in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push_c;
    logic             do_pop_c;

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (count == DEPTH_P);
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign rd_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is unreset; only slots behind wr_ptr are ever read.
    always_ff @(posedge i_clk) begin
        if (do_push_c) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver feeding a byte FIFO with sticky error flags.
// Define UART_RX_PARITY_EN for an even-parity bit and the o_parity_err flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_uart_rx,
    input  logic                          i_rd_en,
    output logic [UART_DATA_W-1:0]        o_rd_data,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    input  logic                          i_err_clr,
    output logic                          o_frame_err,
    output logic                          o_overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                          o_parity_err
`endif
);

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned LAST    = CLKS_PER_BIT - 1;

    logic                   rx_m, rx_s;
    uart_rx_state_t         state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [2:0]             idx, idx_d;
    logic [UART_DATA_W-1:0] shreg, shreg_d;
    logic                   push_c, frame_set_c, ovr_set_c, byte_ok_c;
    logic                   half_c, last_c;

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_d, par_set_c;
    assign byte_ok_c = !par_bad;
`else
    assign byte_ok_c = 1'b1;
`endif

    assign half_c = (cnt == CNT_W'(HALF_M1));
    assign last_c = (cnt == CNT_W'(LAST));

    // Two-flop synchroniser, idles high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_uart_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            shreg <= shreg_d;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt + CNT_W'(1);
        idx_d       = idx;
        shreg_d     = shreg;
        push_c      = 1'b0;
        frame_set_c = 1'b0;
        ovr_set_c   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad;
        par_set_c   = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (half_c) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            DATA: begin
                if (last_c) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg[UART_DATA_W-1:1]};
                    idx_d   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (last_c) begin
                    cnt_d     = '0;
                    par_bad_d = ^{rx_s, shreg};
                    par_set_c = ^{rx_s, shreg};
                    state_d   = STOP;
                end
            end
`endif
            // A read in the same cycle frees a slot in a full FIFO.
            STOP: begin
                if (last_c) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                        if (byte_ok_c) begin
                            if (!o_full || i_rd_en) push_c    = 1'b1;
                            else                    ovr_set_c = 1'b1;
                        end
                    end else begin
                        frame_set_c = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky flags: a new error event takes priority over a clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
        end else begin
            if (frame_set_c)    o_frame_err <= 1'b1;
            else if (i_err_clr) o_frame_err <= 1'b0;
            if (ovr_set_c)      o_overrun   <= 1'b1;
            else if (i_err_clr) o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (par_set_c)      o_parity_err <= 1'b1;
            else if (i_err_clr) o_parity_err <= 1'b0;
`endif
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (push_c),
        .push_data (shreg),
        .pop       (i_rd_en),
        .rd_data   (o_rd_data),
        .empty     (o_empty),
        .full      (o_full),
        .count     (o_count)
    );

endmodule
